// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-bit ALU between two requesters.
// Grants in IDLE, drives the ALU for one EXEC cycle, returns the result in RESP.
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [3:0]       fun0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [3:0]       fun1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_fun,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_last, w_last_nxt;
    logic             r_gnt, w_gnt_nxt;
    logic [WIDTH-1:0] r_alu_a, w_alu_a_nxt;
    logic [WIDTH-1:0] r_alu_b, w_alu_b_nxt;
    logic [3:0]       r_alu_fun, w_alu_fun_nxt;
    logic [WIDTH-1:0] r_res, w_res_nxt;
    logic             r_carry, w_carry_nxt;
    logic             r_err, w_err_nxt;

    logic             w_win;
    logic [WIDTH-1:0] w_sel_a, w_sel_b;
    logic [3:0]       w_sel_fun;
    logic             w_legal;

    // On contention the requester that did not win last time gets the ALU.
    assign w_win     = (req0 && req1) ? ~r_last : req1;
    assign w_sel_a   = w_win ? a1 : a0;
    assign w_sel_b   = w_win ? b1 : b0;
    assign w_sel_fun = w_win ? fun1 : fun0;
    assign w_legal   = w_sel_fun[3] ? (w_sel_fun[2:1] == 2'b00) : (w_sel_fun[2:0] <= 3'd5);

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_gnt_nxt     = r_gnt;
        w_alu_a_nxt   = r_alu_a;
        w_alu_b_nxt   = r_alu_b;
        w_alu_fun_nxt = r_alu_fun;
        w_res_nxt     = r_res;
        w_carry_nxt   = r_carry;
        w_err_nxt     = r_err;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_gnt_nxt  = w_win;
                    w_last_nxt = w_win;
                    if (w_legal) begin
                        w_alu_a_nxt   = w_sel_a;
                        w_alu_b_nxt   = w_sel_b;
                        w_alu_fun_nxt = w_sel_fun;
                        w_state_nxt   = EXEC;
                    end else begin
                        // Reserved code: skip the ALU and answer with an error.
                        w_alu_a_nxt   = '0;
                        w_alu_b_nxt   = '0;
                        w_alu_fun_nxt = '0;
                        w_res_nxt     = '0;
                        w_carry_nxt   = 1'b0;
                        w_err_nxt     = 1'b1;
                        w_state_nxt   = RESP;
                    end
                end
            end
            EXEC: begin
                w_res_nxt     = alu_out;
                w_carry_nxt   = r_alu_fun[3] & alu_carry;
                w_err_nxt     = 1'b0;
                w_alu_a_nxt   = '0;
                w_alu_b_nxt   = '0;
                w_alu_fun_nxt = '0;
                w_state_nxt   = RESP;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_gnt     <= 1'b0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_fun <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_gnt     <= w_gnt_nxt;
            r_alu_a   <= w_alu_a_nxt;
            r_alu_b   <= w_alu_b_nxt;
            r_alu_fun <= w_alu_fun_nxt;
            r_res     <= w_res_nxt;
            r_carry   <= w_carry_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_fun = r_alu_fun;
    assign done0   = (r_state == RESP) && !r_gnt;
    assign done1   = (r_state == RESP) &&  r_gnt;
    assign res     = (r_state == RESP) ? r_res : '0;
    assign carry   = (r_state == RESP) && r_carry;
    assign err     = (r_state == RESP) && r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level model checked every cycle
// plus literal expectations per scenario.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, fun0 = '0;
    logic [3:0] a1 = '0, b1 = '0, fun1 = '0;
    logic [3:0] alu_a, alu_b, alu_fun, alu_out, res;
    logic       alu_carry, done0, done1, carry, err;
    logic [19:0] outs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .fun0(fun0),
        .req1(req1), .a1(a1), .b1(b1), .fun1(fun1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .done0(done0), .done1(done1), .res(res), .carry(carry), .err(err)
    );

    assign outs = {done0, done1, res, carry, err, alu_a, alu_b, alu_fun};

    // Stand-in combinational ALU; carry is the adder carry even for logic ops.
    logic [4:0] sum;
    always_comb begin
        sum = {1'b0, alu_a} + {1'b0, (alu_fun[0] ? ~alu_b : alu_b)} + {4'b0, alu_fun[0]};
        alu_carry = sum[4];
        case (alu_fun)
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            4'b0010: alu_out = ~(alu_a & alu_b);
            4'b0011: alu_out = ~(alu_a | alu_b);
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = ~alu_a;
            default: alu_out = sum[3:0];
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // What the requester should get back, from the function code alone.
    task automatic model_op(input logic [3:0] a, b, f,
                            output logic [3:0] r, output logic c, output logic e);
        logic [4:0] s;
        r = '0; c = 1'b0; e = 1'b0;
        s = {1'b0, a} + {1'b0, b};
        case (f)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = ~(a & b);
            4'd3: r = ~(a | b);
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd8: begin r = s[3:0]; c = s[4]; end
            4'd9: begin r = a - b; c = (a >= b); end
            default: e = 1'b1;
        endcase
    endtask

    // Model: schedule of cycles. Grant at edge e: legal op shows operands in
    // cycle e and responds in e+1; reserved op responds in e. Arbiter is free
    // again 3 (legal) or 2 (reserved) edges after the grant.
    int         cyc = 0, free_at = 0, exec_c = -10, resp_c = -10;
    logic       m_last = 1'b1, m_gnt = 1'b0, m_car = 1'b0, m_err = 1'b0;
    logic [3:0] m_a = '0, m_b = '0, m_f = '0, m_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            free_at = 0; exec_c = -10; resp_c = -10; m_last = 1'b1;
        end else begin
            cyc++;
            if (cyc >= free_at && (req0 || req1)) begin
                m_gnt  = (req0 && req1) ? ~m_last : req1;
                m_last = m_gnt;
                m_a = m_gnt ? a1 : a0;
                m_b = m_gnt ? b1 : b0;
                m_f = m_gnt ? fun1 : fun0;
                model_op(m_a, m_b, m_f, m_res, m_car, m_err);
                if (m_err) begin
                    exec_c = -10; resp_c = cyc; free_at = cyc + 2;
                end else begin
                    exec_c = cyc; resp_c = cyc + 1; free_at = cyc + 3;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic        in_resp, in_exec;
        logic [19:0] exp;
        in_resp = !rst && (cyc == resp_c);
        in_exec = !rst && (cyc == exec_c);
        exp = {in_resp && !m_gnt, in_resp && m_gnt,
               in_resp ? m_res : 4'h0, in_resp && m_car, in_resp && m_err,
               in_exec ? m_a : 4'h0, in_exec ? m_b : 4'h0, in_exec ? m_f : 4'h0};
        chk("cycle_outputs", outs, exp);
    end

    task automatic do_op(input bit r, input logic [3:0] a, b, f,
                         input logic [3:0] eres, input bit ecar, eerr, input int elat);
        bit got = 0;
        @(negedge clk);
        if (!r) begin req0 = 1; a0 = a; b0 = b; fun0 = f; end
        else    begin req1 = 1; a1 = a; b1 = b; fun1 = f; end
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            if (k == 1) chk("alu_fun_exec", alu_fun, eerr ? 4'h0 : f);
            if (r ? done1 : done0) begin
                got = 1;
                chk("latency", k, elat);
                chk("res", res, eres);
                chk("carry", carry, ecar);
                chk("err", err, eerr);
                chk("other_done", r ? done0 : done1, 0);
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        req0 = 0; req1 = 0;
    endtask

    int ord[4], rs[4], at[4];

    task automatic run_both(input int n);
        int got = 0;
        for (int k = 1; k <= 40 && got < n; k++) begin
            @(negedge clk);
            if (done0 || done1) begin
                ord[got] = done1 ? 1 : 0;
                rs[got]  = int'(res);
                at[got]  = k;
                got++;
            end
        end
        if (got < n) chk("arb_timeout", got, n);
        req0 = 0; req1 = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1;
        #1 chk("reset_outs", outs, 0);
        @(negedge clk);
        #3 rst = 0;
    endtask

    initial begin
        int cnt;
        #1 chk("por_outs", outs, 0);
        @(negedge clk);
        #3 rst = 0;

        do_op(0, 4'h7, 4'h5, 4'b1000, 4'hC, 0, 0, 2);
        do_op(1, 4'h5, 4'h3, 4'b1001, 4'h2, 1, 0, 2);
        do_op(1, 4'h3, 4'h5, 4'b1001, 4'hE, 0, 0, 2);
        do_op(0, 4'h9, 4'h4, 4'b0110, 4'h0, 0, 1, 1);
        do_op(0, 4'h9, 4'h4, 4'b1010, 4'h0, 0, 1, 1);
        do_op(0, 4'hF, 4'h1, 4'b1000, 4'h0, 1, 0, 2);

        // Both requesters held from reset: strict alternation, 3-cycle spacing.
        do_reset();
        @(negedge clk);
        req0 = 1; a0 = 4'hC; b0 = 4'hA; fun0 = 4'b0000;
        req1 = 1; a1 = 4'hC; b1 = 4'hA; fun1 = 4'b0100;
        run_both(4);
        for (int i = 0; i < 4; i++) begin
            chk("arb_order", ord[i], i % 2);
            chk("arb_res", rs[i], (i % 2) ? 6 : 8);
            if (i > 0) chk("arb_gap", at[i] - at[i-1], 3);
        end

        // Reset during EXEC: op is lost, no done afterwards.
        @(negedge clk);
        req0 = 1; a0 = 4'h7; b0 = 4'h5; fun0 = 4'b1000;
        @(posedge clk);
        #2 rst = 1;
        #1 chk("midop_reset_outs", outs, 0);
        req0 = 0;
        @(negedge clk);
        #3 rst = 0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(done0 | done1);
        end
        chk("no_done_after_abort", cnt, 0);

        // Requester 0 has priority again after reset.
        @(negedge clk);
        req0 = 1; a0 = 4'h1; b0 = 4'h2; fun0 = 4'b1000;
        req1 = 1; a1 = 4'h5; b1 = 4'hA; fun1 = 4'b0001;
        run_both(2);
        chk("post_reset_first", ord[0], 0);
        chk("post_reset_res0", rs[0], 3);
        chk("post_reset_second", ord[1], 1);
        chk("post_reset_res1", rs[1], 15);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
